// File: rtl/query_patch_pkg.sv
// Shared types and constants for the query patch read path.
// Patch width, address width and the reader FSM encoding.
package query_patch_pkg;

  localparam int DATA_WIDTH  = 11;
  localparam int PATCH_SIZE  = 5;
  localparam int PATCH_W     = DATA_WIDTH * PATCH_SIZE;
  localparam int QADDR_WIDTH = 9;

  typedef logic [PATCH_W-1:0]     patch_t;
  typedef logic [QADDR_WIDTH-1:0] qaddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qpr_state_t;

endpackage

// File: rtl/patch_fifo.sv
// Three-entry synchronous FIFO for {addr, patch} words.
// Head word is always visible on rdata; reset clears storage.
module patch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   occ,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [3];
  logic [1:0]   wp_q, wp_d;
  logic [1:0]   rp_q, rp_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_push, do_pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign full    = (occ_q == 2'd3);
  assign empty   = (occ_q == 2'd0);
  assign occ     = occ_q;
  assign rdata   = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wp_d  = do_push ? nxt(wp_q) : wp_q;
    rp_d  = do_pop ? nxt(rp_q) : rp_q;
    occ_d = occ_q;
    unique case (1'b1)
      do_push && !do_pop: occ_d = occ_q + 2'd1;
      do_pop && !do_push: occ_d = occ_q - 2'd1;
      default:            occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
      if (do_push) mem_q[wp_q] <= wdata;
    end
  end

endmodule

// File: rtl/query_patch_reader.sv
// Read sequencer for the query patch memory: issues port-1 reads,
// buffers the one-cycle SRAM latency and streams patches in order.
module query_patch_reader
  import query_patch_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH:0]              count,
  output logic                             busy,
  output logic                             done,
  output logic                             csb1,
  output logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] out_patch,
  output logic [ADDR_WIDTH-1:0]            out_addr
);

  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam int CW = ADDR_WIDTH + 1;

  qpr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] addr1_q;
  logic [ADDR_WIDTH-1:0] inaddr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         popped_q, popped_d;
  logic                  inflight_q;
  logic                  issue, pop;
  logic [1:0]            occ;
  logic                  full, empty;
  logic [ADDR_WIDTH+PW-1:0] fifo_rdata;

  // Issue decision uses only registered state, never out_ready.
  assign issue = (state_q == RUN)
              && (issued_q < cnt_q)
              && !full
              && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd3);

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign csb1      = !issue;
  assign addr1     = issue ? rd_addr_q : addr1_q;

  assign {out_addr, out_patch} = fifo_rdata;

  patch_fifo #(
    .W(ADDR_WIDTH + PW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .wdata({inaddr_q, rpatch1}),
    .rdata(fifo_rdata),
    .occ  (occ),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    popped_d  = popped_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = count;
          rd_addr_d = base_addr;
          issued_d  = '0;
          popped_d  = '0;
          state_d   = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          issued_d  = issued_q + CW'(1);
        end
        if (pop) begin
          popped_d = popped_q + CW'(1);
          if (popped_q + CW'(1) == cnt_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      addr1_q    <= '0;
      inaddr_q   <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      addr1_q    <= addr1;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= issue;
      if (issue) inaddr_q <= rd_addr_q;
    end
  end

endmodule

// File: tb/tb_query_patch_reader.sv
// Scoreboard bench for query_patch_reader with a behavioural
// one-cycle-latency memory on read port 1.
module tb_query_patch_reader;

  localparam int AW = 9;
  localparam int PW = 55;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, csb1, out_valid;
  logic [AW-1:0] addr1, out_addr;
  logic [PW-1:0] out_patch;
  logic [PW-1:0] rpatch1 = '0;
  logic          out_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int issues, pops, first_iss, first_val, done_rel, maxout;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [PW-1:0] prev_patch;
  int exp_q[$];
  int iss_q[$];

  query_patch_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .csb1     (csb1),
    .addr1    (addr1),
    .rpatch1  (rpatch1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_patch(out_patch),
    .out_addr (out_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] pat(input int a);
    logic [PW-1:0] v;
    v = PW'(a) * PW'(3);
    v = v + (PW'(a) << 44);
    return v;
  endfunction

  always @(posedge clk) if (!csb1) rpatch1 <= pat(int'(addr1));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    int rel;
    int e;
    if (mon_en) begin
      rel = cyc - t0;
      if (!csb1) begin
        issues++;
        if (first_iss < 0) first_iss = rel;
        if (iss_q.size() == 0) chk("extra_issue", 64'(addr1), 64'hFFFF);
        else chk("addr1", 64'(addr1), 64'(iss_q.pop_front()));
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_addr", 64'(out_addr), 64'(prev_addr));
        chk("hold_patch", 64'(out_patch), 64'(prev_patch));
      end
      if (out_valid && first_val < 0) first_val = rel;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("extra_pop", 64'(out_addr), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("out_addr", 64'(out_addr), 64'(e));
          chk("out_patch", 64'(out_patch), 64'(pat(e)));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_patch = out_patch;
      if (issues - pops > maxout) maxout = issues - pops;
      if (done && done_rel < 0) begin
        done_rel = rel;
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // lo<0 selects random backpressure; poke pulses a stray start in RUN
  task automatic burst(input int b, input int c, input int lo,
                       input int hi, input bit poke);
    int n;
    int rel;
    exp_q.delete();
    iss_q.delete();
    for (int i = 0; i < c; i++) begin
      exp_q.push_back((b + i) % 512);
      iss_q.push_back((b + i) % 512);
    end
    issues = 0; pops = 0; maxout = 0;
    first_iss = -1; first_val = -1; done_rel = -1;
    prev_stall = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    base_addr = AW'(b);
    count = (AW+1)'(c);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_rel < 0 && n < 3000) begin
      rel = cyc - t0;
      if (lo < 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(rel >= lo && rel <= hi);
      if (poke && rel == 2) begin
        start = 1'b1;
        base_addr = AW'(100);
        count = (AW+1)'(1);
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("timeout", 64'(n < 3000), 64'd1);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("left_exp", 64'(exp_q.size()), 64'd0);
    chk("pops", 64'(pops), 64'(c));
    chk("issues", 64'(issues), 64'(c));
    chk("maxout_le3", 64'(maxout <= 3), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_csb1", 64'(csb1), 64'd1);
    chk("rst_addr1", 64'(addr1), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_patch", 64'(out_patch), 64'd0);
    chk("rst_oaddr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    burst(0, 5, 1000, 1000, 1'b0);
    chk("t1_first_iss", 64'(first_iss), 64'd1);
    chk("t1_first_val", 64'(first_val), 64'd3);
    chk("t1_done_rel", 64'(done_rel), 64'd8);

    burst(10, 8, 3, 9, 1'b0);
    chk("t2_maxout", 64'(maxout), 64'd3);

    burst(510, 4, 1000, 1000, 1'b0);

    burst(0, 0, 1000, 1000, 1'b0);
    chk("c0_done_rel", 64'(done_rel), 64'd1);
    chk("c0_no_valid", 64'(first_val), 64'hFFFF_FFFF_FFFF_FFFF);

    burst(200, 3, 1000, 1000, 1'b1);

    burst(300, 512, -1, 0, 1'b0);

    burst(37, 20, -1, 0, 1'b0);

    mon_en = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    base_addr = '0;
    count = (AW+1)'(6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_csb1", 64'(csb1), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_oaddr", 64'(out_addr), 64'd0);
    mon_en = 1'b1;

    burst(0, 2, 1000, 1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
